// File: rtl/fda_uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encoding,
// data width, frame-length constants and a small parity helper.
package fda_uart_pkg;

  localparam int DATA_BITS      = 8;
  localparam int BIT_IDX_W      = $clog2(DATA_BITS);
  // Frame lengths in bit slots: start + data + [parity] + stop.
  localparam int FRAME_BITS_8N1 = 1 + DATA_BITS + 1;
  localparam int FRAME_BITS_8E1 = 1 + DATA_BITS + 1 + 1;
  localparam int SLOT_W         = $clog2(FRAME_BITS_8E1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Observation bundle: current state, data bit index and the bit slot of
  // the frame currently being driven (0 = start bit).
  typedef struct packed {
    tx_state_e             state;
    logic [BIT_IDX_W-1:0]  bit_idx;
    logic [SLOT_W-1:0]     frame_slot;
  } tx_dbg_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/fda_sync_fifo.sv
// Single-clock FIFO with an extra pointer bit for full/empty detection.
// A push while full is accepted only if a pop happens in the same cycle;
// a pop while empty is ignored.
module fda_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic                wr_en;
  logic                rd_en;

  // Status flags and pointer advance; pointers wrap naturally modulo 2*DEPTH.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {DEPTH_LOG2{1'b0}}});
    count    = wr_ptr_q - rd_ptr_q;
    rd_en    = pop && !empty;
    wr_en    = push && (!full || rd_en);
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    pop_data = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are meaningless until written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter. Bytes written with a one-cycle txDataWr strobe
// are queued in a FIFO and sent LSB first as 8N1 frames (8E1 when the
// UART_TX_PARITY_EN macro is defined). Consecutive frames are sent without
// an idle gap. Writes that find the FIFO full are dropped and latch overflow.
//
// Handshake: there is no ready; a byte is taken whenever txDataWr=1 and the
// FIFO is not full (or is full but pops in that same cycle). Otherwise it is
// dropped and the sticky overflow flag is set.
module uart_tx_buffered
  import fda_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT    = 868,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic [7:0]                 txData,
  input  logic                       txDataWr,
  input  logic                       clrOverflow,
  output logic                       txSerial,
  output logic                       txBusy,
  output logic                       fifoFull,
  output logic [FIFO_DEPTH_LOG2:0]   fifoCount,
  output logic                       overflow,
  output tx_dbg_t                    txDbg
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] BIT_LAST  = BIT_IDX_W'(DATA_BITS - 1);
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = FRAME_BITS_8E1;
`else
  localparam int FRAME_BITS = FRAME_BITS_8N1;
`endif

  tx_state_e            state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic                 tx_serial_q, tx_serial_d;
  logic                 busy_q, busy_d;
  logic                 overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic                     bit_done;
  logic                     fifo_pop;
  logic [7:0]               fifo_dout;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [FIFO_DEPTH_LOG2:0] fifo_count;
  logic                     wr_drop;

  fda_sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rstN),
    .push      (txDataWr),
    .push_data (txData),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bit_done = (baud_q == BAUD_LAST);
  assign wr_drop  = txDataWr && fifo_full && !fifo_pop;

  // Next-state logic: baud timing, bit sequencing and FIFO pops.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    if (state_q != ST_IDLE) baud_d = bit_done ? '0 : baud_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
`ifdef UART_TX_PARITY_EN
          parity_d = even_parity(fifo_dout);
`endif
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        // Chain the next frame straight from the last stop cycle.
        if (bit_done) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
`ifdef UART_TX_PARITY_EN
            parity_d = even_parity(fifo_dout);
`endif
            state_d  = ST_START;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level, busy and sticky overflow; all registered so the pin is glitch-free.
  always_comb begin
    tx_serial_d = 1'b1;
    case (state_q)
      ST_START:  tx_serial_d = 1'b0;
      ST_DATA:   tx_serial_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_serial_d = parity_q;
`endif
      default:   tx_serial_d = 1'b1;
    endcase
    busy_d     = (state_q != ST_IDLE) || !fifo_empty;
    // A drop in the same cycle as a clear keeps the flag set.
    overflow_d = wr_drop ? 1'b1 : (clrOverflow ? 1'b0 : overflow_q);
  end

  // State registers; reset drops any partial frame and forces the line idle.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= ST_IDLE;
      baud_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      tx_serial_q <= 1'b1;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      tx_serial_q <= tx_serial_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  // Debug view of the FSM position within the frame.
  always_comb begin
    txDbg.state      = state_q;
    txDbg.bit_idx    = bit_idx_q;
    txDbg.frame_slot = '0;
    case (state_q)
      ST_DATA:   txDbg.frame_slot = SLOT_W'(1) + SLOT_W'(bit_idx_q);
      ST_PARITY: txDbg.frame_slot = SLOT_W'(FRAME_BITS_8N1 - 1);
      ST_STOP:   txDbg.frame_slot = SLOT_W'(FRAME_BITS - 1);
      default:   txDbg.frame_slot = '0;
    endcase
  end

  assign txSerial  = tx_serial_q;
  assign txBusy    = busy_q;
  assign fifoFull  = fifo_full;
  assign fifoCount = fifo_count;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered with CLKS_PER_BIT=4, FIFO_DEPTH_LOG2=2.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx_buffered;
  import fda_uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DL2   = 2;
  localparam int DEPTH = 1 << DL2;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FL   = FB * CPB;
  localparam int HIST = 4096;

  // Clock / reset and DUT
  logic           clk = 1'b0;
  logic           rstN = 1'b0;
  logic [7:0]     txData = 8'h00;
  logic           txDataWr = 1'b0;
  logic           clrOverflow = 1'b0;
  logic           txSerial, txBusy, fifoFull, overflow;
  logic [DL2:0]   fifoCount;
  tx_dbg_t        tx_dbg;

  always #5 clk = ~clk;

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rstN(rstN), .txData(txData), .txDataWr(txDataWr),
    .clrOverflow(clrOverflow), .txSerial(txSerial), .txBusy(txBusy),
    .fifoFull(fifoFull), .fifoCount(fifoCount), .overflow(overflow),
    .txDbg(tx_dbg)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // History recorder: index n holds outputs after rising edge n.
  int   cyc = 0;
  logic line_h [HIST];
  logic busy_h [HIST];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (cyc < HIST) begin
      line_h[cyc] = txSerial;
      busy_h[cyc] = txBusy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference frame model: bit at slot p of the frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int p);
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
`ifdef UART_TX_PARITY_EN
    if (p == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Counts line cycles deviating from the expected back-to-back frame stream.
  task automatic count_line_errs(input int start, input logic [7:0] bytes[$],
                                 output int errs, output int first_bad);
    int idx;
    errs = 0;
    first_bad = -1;
    for (int f = 0; f < bytes.size(); f++)
      for (int p = 0; p < FB; p++)
        for (int c = 0; c < CPB; c++) begin
          idx = start + (f * FB + p) * CPB + c;
          if (idx >= HIST || line_h[idx] !== exp_bit(bytes[f], p)) begin
            errs++;
            if (first_bad < 0) first_bad = idx;
          end
        end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  // Strobes bytes on consecutive cycles; k is the edge sampling the first one.
  task automatic write_burst(input logic [7:0] bytes[$], output int k);
    tick();
    k = cyc + 1;
    for (int i = 0; i < bytes.size(); i++) begin
      txData   = bytes[i];
      txDataWr = 1'b1;
      tick();
    end
    txDataWr = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (3) tick();
    n_checks++; if (txSerial !== 1'b1) $display("FAIL reset_line: got %b want 1", txSerial); else n_pass++;
    n_checks++; if (txBusy !== 1'b0) $display("FAIL reset_busy: got %b want 0", txBusy); else n_pass++;
    n_checks++; if (fifoFull !== 1'b0) $display("FAIL reset_full: got %b want 0", fifoFull); else n_pass++;
    n_checks++; if (fifoCount !== '0) $display("FAIL reset_count: got %0d want 0", fifoCount); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
    n_checks++; if (tx_dbg.state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", tx_dbg.state, ST_IDLE); else n_pass++;
    rstN = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single_frame();
    logic [7:0] q[$];
    int k, errs, bad;
    q.push_back(8'h41);
    write_burst(q, k);
    n_checks++; if (fifoCount !== 3'(1) && cyc == k) $display("FAIL single_count: got %0d want 1", fifoCount); else n_pass++;
    wait_until(k + FL + 4);
    n_checks++; if (line_h[k+1] !== 1'b1) $display("FAIL single_no_bypass: line %b at k+1 want 1", line_h[k+1]); else n_pass++;
    n_checks++; if (line_h[k+2] !== 1'b0) $display("FAIL single_latency: line %b at k+2 want 0", line_h[k+2]); else n_pass++;
    count_line_errs(k + 2, q, errs, bad);
    n_checks++; if (errs !== 0) $display("FAIL single_frame: %0d bad cycles, first at %0d, want 0", errs, bad); else n_pass++;
    n_checks++; if (busy_h[k+FL+1] !== 1'b1) $display("FAIL single_busy_hold: got %b want 1", busy_h[k+FL+1]); else n_pass++;
    n_checks++; if (busy_h[k+FL+2] !== 1'b0) $display("FAIL single_busy_drop: got %b want 0", busy_h[k+FL+2]); else n_pass++;
    n_checks++; if (line_h[k+FL+2] !== 1'b1) $display("FAIL single_idle_after: got %b want 1", line_h[k+FL+2]); else n_pass++;
  endtask

  task automatic test_random_frames();
    logic [7:0] q[$];
    int k, errs, bad;
    for (int i = 0; i < 3; i++) begin
      q.delete();
      q.push_back(8'($urandom_range(0, 255)));
      write_burst(q, k);
      wait_until(k + FL + 4);
      count_line_errs(k + 2, q, errs, bad);
      n_checks++; if (errs !== 0) $display("FAIL random_frame %0d (0x%02h): %0d bad cycles, first at %0d, want 0", i, q[0], errs, bad); else n_pass++;
      n_checks++; if (busy_h[k+FL+2] !== 1'b0) $display("FAIL random_busy_drop %0d: got %b want 0", i, busy_h[k+FL+2]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    int k, errs, bad, gaps;
    q.push_back(8'h2A);
    q.push_back(8'h21);
    write_burst(q, k);
    wait_until(k + 2 * FL + 4);
    count_line_errs(k + 2, q, errs, bad);
    n_checks++; if (errs !== 0) $display("FAIL b2b_frames: %0d bad cycles, first at %0d, want 0", errs, bad); else n_pass++;
    n_checks++; if (line_h[k+1+FL] !== 1'b1 || line_h[k+2+FL] !== 1'b0)
      $display("FAIL b2b_second_start: got %b%b want 10", line_h[k+1+FL], line_h[k+2+FL]); else n_pass++;
    gaps = 0;
    for (int i = k + 1; i <= k + 2 * FL + 1; i++) if (busy_h[i] !== 1'b1) gaps++;
    n_checks++; if (gaps !== 0) $display("FAIL b2b_busy_gap: %0d idle cycles want 0", gaps); else n_pass++;
    n_checks++; if (busy_h[k+2*FL+2] !== 1'b0) $display("FAIL b2b_busy_drop: got %b want 0", busy_h[k+2*FL+2]); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] sent_q[$];
    logic [7:0] b;
    logic       exp_ovf, pop, drop, clr;
    int         k, occ, errs, bad;
    occ = 0;
    exp_ovf = 1'b0;
    tick();
    k = cyc + 1;
    // DEPTH+3 writes; the last one coincides with clrOverflow while being dropped.
    for (int c = 0; c < DEPTH + 3; c++) begin
      b   = 8'($urandom_range(0, 255));
      clr = (c == DEPTH + 2);
      txData = b; txDataWr = 1'b1; clrOverflow = clr;
      pop  = (c == 1) && (occ > 0);
      drop = (occ == DEPTH) && !pop;
      if (pop) occ--;
      if (!drop) begin occ++; sent_q.push_back(b); end
      exp_ovf = drop ? 1'b1 : (clr ? 1'b0 : exp_ovf);
      tick();
      n_checks++; if (overflow !== exp_ovf) $display("FAIL ovf_flag cycle %0d: got %b want %b", c, overflow, exp_ovf); else n_pass++;
      n_checks++; if (fifoCount !== 3'(occ)) $display("FAIL ovf_count cycle %0d: got %0d want %0d", c, fifoCount, occ); else n_pass++;
      n_checks++; if (fifoFull !== (occ == DEPTH)) $display("FAIL ovf_full cycle %0d: got %b want %b", c, fifoFull, occ == DEPTH); else n_pass++;
    end
    txDataWr = 1'b0; clrOverflow = 1'b0;
    wait_until(k + 2 + sent_q.size() * FL + 2);
    count_line_errs(k + 2, sent_q, errs, bad);
    n_checks++; if (errs !== 0) $display("FAIL ovf_frames: %0d bad cycles, first at %0d, want 0", errs, bad); else n_pass++;
    n_checks++; if (busy_h[k+2+sent_q.size()*FL] !== 1'b0) $display("FAIL ovf_busy_drop: got %b want 0", busy_h[k+2+sent_q.size()*FL]); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
    clrOverflow = 1'b1;
    tick();
    clrOverflow = 1'b0;
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow); else n_pass++;
  endtask

  task automatic test_full_pop();
    logic [7:0] q[$];
    int k, errs, bad;
    for (int i = 0; i <= DEPTH; i++) q.push_back(8'($urandom_range(0, 255)));
    write_burst(q, k);
    // Edge k+1+FL is the last stop cycle of the first frame, which pops.
    wait_until(k + FL);
    n_checks++; if (fifoFull !== 1'b1 || fifoCount !== 3'(DEPTH))
      $display("FAIL fullpop_pre: full %b count %0d want 1 %0d", fifoFull, fifoCount, DEPTH); else n_pass++;
    q.push_back(8'($urandom_range(0, 255)));
    txData = q[DEPTH + 1]; txDataWr = 1'b1;
    tick();
    txDataWr = 1'b0;
    n_checks++; if (fifoCount !== 3'(DEPTH)) $display("FAIL fullpop_count: got %0d want %0d", fifoCount, DEPTH); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL fullpop_overflow: got %b want 0", overflow); else n_pass++;
    wait_until(k + 2 + q.size() * FL + 2);
    count_line_errs(k + 2, q, errs, bad);
    n_checks++; if (errs !== 0) $display("FAIL fullpop_frames: %0d bad cycles, first at %0d, want 0", errs, bad); else n_pass++;
    n_checks++; if (busy_h[k+2+q.size()*FL] !== 1'b0) $display("FAIL fullpop_busy_drop: got %b want 0", busy_h[k+2+q.size()*FL]); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] q[$];
    int k, r, lows, busys;
    q.push_back(8'($urandom_range(0, 255)) & 8'hF7);
    q.push_back(8'($urandom_range(0, 255)));
    q.push_back(8'($urandom_range(0, 255)));
    write_burst(q, k);
    wait_until(k + 2 + 4 * CPB + 1);
    n_checks++; if (txSerial !== 1'b0) $display("FAIL rstmid_bit3: got %b want 0", txSerial); else n_pass++;
    n_checks++; if (fifoCount !== 3'(2)) $display("FAIL rstmid_buffered: got %0d want 2", fifoCount); else n_pass++;
    rstN = 1'b0;
    #1;
    n_checks++; if (txSerial !== 1'b1) $display("FAIL rstmid_line: got %b want 1", txSerial); else n_pass++;
    n_checks++; if (fifoCount !== '0) $display("FAIL rstmid_count: got %0d want 0", fifoCount); else n_pass++;
    n_checks++; if (txBusy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", txBusy); else n_pass++;
    repeat (2) tick();
    rstN = 1'b1;
    r = cyc;
    wait_until(r + 3 * FL + 1);
    lows = 0; busys = 0;
    for (int i = r; i < r + 3 * FL; i++) begin
      if (line_h[i] !== 1'b1) lows++;
      if (busy_h[i] !== 1'b0) busys++;
    end
    n_checks++; if (lows !== 0) $display("FAIL rstmid_silent: %0d non-idle line cycles want 0", lows); else n_pass++;
    n_checks++; if (busys !== 0) $display("FAIL rstmid_idle_busy: %0d busy cycles want 0", busys); else n_pass++;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] q[$];
    logic [7:0] vals[2];
    logic       want[2];
    int k, errs, bad;
    vals[0] = 8'h07; want[0] = 1'b1;
    vals[1] = 8'h03; want[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      q.delete();
      q.push_back(vals[i]);
      write_burst(q, k);
      wait_until(k + FL + 4);
      n_checks++; if (line_h[k+2+9*CPB+1] !== want[i])
        $display("FAIL parity_bit 0x%02h: got %b want %b", vals[i], line_h[k+2+9*CPB+1], want[i]); else n_pass++;
      count_line_errs(k + 2, q, errs, bad);
      n_checks++; if (errs !== 0) $display("FAIL parity_frame 0x%02h: %0d bad cycles want 0", vals[i], errs); else n_pass++;
      n_checks++; if (busy_h[k+1+FL] !== 1'b1 || busy_h[k+2+FL] !== 1'b0)
        $display("FAIL parity_length 0x%02h: busy %b%b want 10", vals[i], busy_h[k+1+FL], busy_h[k+2+FL]); else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_random_frames();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
